// File: rtl/auv_mtimer.sv
// auv_mtimer: machine timer peripheral.
// Holds the 64-bit mtime counter, a DIV+1 prescaler and the mtimecmp compare
// register, and raises the registered level interrupt int_timer whenever
// mtime >= mtimecmp. Software access is over a 32-bit sel/adr/rd/wr/ack bus.
//
// Optional feature: define AUV_MTIMER_SNAPSHOT_EN to latch mtime[63:32] into a
// shadow on every read of address 0 and return that shadow on reads of
// address 1, giving a coherent 64-bit read across a low-word carry.
//
// Bus handshake: a request is present in any cycle where bus_sel is high and
// bus_rd or bus_wr is high; bus_rd wins over bus_wr. A request to a mapped
// word address (0-4) is serviced in that same cycle and answered by bus_ack
// high for exactly one cycle on the following cycle, with bus_dat_rd valid
// alongside it (zero for writes). Requests held high are serviced every
// cycle. Unmapped addresses (5-7) get no ack and change nothing.
module auv_mtimer #(
   parameter int          PRESCALE_WIDTH = 8,
   parameter logic [63:0] MTIMECMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        halt,
   input  logic        bus_sel,
   input  logic [2:0]  bus_adr,
   input  logic [31:0] bus_dat_wr,
   output logic [31:0] bus_dat_rd,
   input  logic        bus_rd,
   input  logic        bus_wr,
   output logic        bus_ack,
   output logic        int_timer
);

   localparam logic [2:0] ADR_MTIME_LO = 3'd0;
   localparam logic [2:0] ADR_MTIME_HI = 3'd1;
   localparam logic [2:0] ADR_CMP_LO   = 3'd2;
   localparam logic [2:0] ADR_CMP_HI   = 3'd3;
   localparam logic [2:0] ADR_CTRL     = 3'd4;

   localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   // State registers
   logic [63:0]               mtime_q, mtime_d;
   logic [63:0]               mtimecmp_q, mtimecmp_d;
   logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
   logic [PRESCALE_WIDTH-1:0] div_q, div_d;
   logic                      en_q, en_d;
   logic                      int_timer_q, int_timer_d;
   logic                      bus_ack_q, bus_ack_d;
   logic [31:0]               bus_dat_rd_q, bus_dat_rd_d;
`ifdef AUV_MTIMER_SNAPSHOT_EN
   logic [31:0]               shadow_q, shadow_d;
`endif

   // Decoded access and helper signals
   logic        req;
   logic        mapped;
   logic        rd_en;
   logic        wr_en;
   logic        tick;
   logic [31:0] ctrl_word;
   logic [31:0] mtime_hi_rd;

   // Decode the bus request; read takes priority over write
   always_comb begin
      req    = bus_sel & (bus_rd | bus_wr);
      mapped = (bus_adr <= ADR_CTRL);
      rd_en  = req & bus_rd & mapped;
      wr_en  = req & ~bus_rd & bus_wr & mapped;
   end

   // Read-back views: ctrl with unused bits zero, and the high mtime word
   always_comb begin
      ctrl_word                       = '0;
      ctrl_word[0]                    = en_q;
      ctrl_word[8 +: PRESCALE_WIDTH]  = div_q;
`ifdef AUV_MTIMER_SNAPSHOT_EN
      mtime_hi_rd = shadow_q;
`else
      mtime_hi_rd = mtime_q[63:32];
`endif
   end

   // Prescaler and mtime counting; bus writes override the increment
   always_comb begin
      tick    = en_q & ~halt & (presc_q == div_q);
      presc_d = presc_q;
      if (en_q && !halt) begin
         presc_d = tick ? '0 : presc_q + PRESC_ONE;
      end
      if (wr_en && bus_adr == ADR_CTRL) begin
         presc_d = '0;
      end

      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr_en && bus_adr == ADR_MTIME_LO) begin
         mtime_d = {mtime_q[63:32], bus_dat_wr};
      end else if (wr_en && bus_adr == ADR_MTIME_HI) begin
         mtime_d = {bus_dat_wr, mtime_q[31:0]};
      end
   end

   // Compare and control register writes
   always_comb begin
      mtimecmp_d = mtimecmp_q;
      en_d       = en_q;
      div_d      = div_q;
      if (wr_en) begin
         case (bus_adr)
            ADR_CMP_LO: mtimecmp_d[31:0]  = bus_dat_wr;
            ADR_CMP_HI: mtimecmp_d[63:32] = bus_dat_wr;
            ADR_CTRL: begin
               en_d  = bus_dat_wr[0];
               div_d = bus_dat_wr[8 +: PRESCALE_WIDTH];
            end
            default: ;
         endcase
      end
   end

   // Read data, acknowledge and interrupt, all registered from request-cycle values
   always_comb begin
      bus_ack_d    = rd_en | wr_en;
      bus_dat_rd_d = '0;
      if (rd_en) begin
         case (bus_adr)
            ADR_MTIME_LO: bus_dat_rd_d = mtime_q[31:0];
            ADR_MTIME_HI: bus_dat_rd_d = mtime_hi_rd;
            ADR_CMP_LO:   bus_dat_rd_d = mtimecmp_q[31:0];
            ADR_CMP_HI:   bus_dat_rd_d = mtimecmp_q[63:32];
            ADR_CTRL:     bus_dat_rd_d = ctrl_word;
            default:      bus_dat_rd_d = '0;
         endcase
      end
      int_timer_d = (mtime_q >= mtimecmp_q);
   end

`ifdef AUV_MTIMER_SNAPSHOT_EN
   // Shadow captures the high word on a low-word read, or takes a high-word write
   always_comb begin
      shadow_d = shadow_q;
      if (rd_en && bus_adr == ADR_MTIME_LO) begin
         shadow_d = mtime_q[63:32];
      end else if (wr_en && bus_adr == ADR_MTIME_HI) begin
         shadow_d = bus_dat_wr;
      end
   end

   // Shadow register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
      end else begin
         shadow_q <= shadow_d;
      end
   end
`endif

   // Main state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime_q      <= '0;
         mtimecmp_q   <= MTIMECMP_RST;
         presc_q      <= '0;
         div_q        <= '0;
         en_q         <= 1'b0;
         int_timer_q  <= 1'b0;
         bus_ack_q    <= 1'b0;
         bus_dat_rd_q <= '0;
      end else begin
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         presc_q      <= presc_d;
         div_q        <= div_d;
         en_q         <= en_d;
         int_timer_q  <= int_timer_d;
         bus_ack_q    <= bus_ack_d;
         bus_dat_rd_q <= bus_dat_rd_d;
      end
   end

   assign bus_ack    = bus_ack_q;
   assign bus_dat_rd = bus_dat_rd_q;
   assign int_timer  = int_timer_q;

endmodule
